// File: rtl/game_pkg.sv
// Shared encodings for the game FSM and its event generator.
// One-hot states/events, mode and hit-result codes.
package game_pkg;

  typedef enum logic [3:0] {
    ST_BEFORE = 4'b0001,
    ST_IN     = 4'b0010,
    ST_LOST   = 4'b0100,
    ST_WIN    = 4'b1000
  } state_e;

  typedef enum logic [3:0] {
    SIG_KEEP  = 4'b0001,
    SIG_WIN   = 4'b0010,
    SIG_START = 4'b0100,
    SIG_LOST  = 4'b1000
  } sig_e;

  typedef enum logic [1:0] {
    MODE_DEAD  = 2'b01,
    MODE_LEVEL = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    HIT_LOST = 2'b01,
    HIT_SUCC = 2'b10,
    HIT_NONE = 2'b11
  } hit_e;

  // Any code other than Dead plays as Level.
  function automatic logic is_dead(input logic [1:0] m);
    return m == MODE_DEAD;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Start-button synchronizer + debouncer; one-cycle press_pulse.
// Ports: clk, rst (async, active-low), btn_raw in; press_pulse out.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2;
  logic [1:0]    fill;
  logic          locked;
  logic [CW-1:0] cnt;

  // locked discards a press held across reset: it clears only once the
  // flushed synchronizer has shown the button low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      fill        <= 2'b00;
      locked      <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
      if (fill[1] && !s2)
        locked <= 1'b0;
      // Saturating at DEBOUNCE_CYCLES gives one pulse per hold.
      if (!s2)
        cnt <= '0;
      else if (cnt != CW'(DEBOUNCE_CYCLES))
        cnt <= cnt + CW'(1);
      press_pulse <= s2 && !locked &&
                     cnt == CW'(DEBOUNCE_CYCLES - 1);
    end
  end

endmodule

// File: rtl/game_sig_gen.sv
// Game event generator: score/lives/time counters, win/lose/start events.
// Ports: clk, rst, start_btn, tick_1s, mode, hit_*, state in; gameSig, score, lives, time_left out.
module game_sig_gen
  import game_pkg::*;
#(
  parameter int TARGET_SCORE    = 20,
  parameter int TIME_LIMIT      = 60,
  parameter int INIT_LIVES      = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       tick_1s,
  input  logic [1:0] mode,
  input  logic       hit_valid,
  input  logic [1:0] hit_result,
  input  logic [3:0] state,
  output logic [3:0] gameSig,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [6:0] time_left
);

  logic       press;
  logic       dead_q, end_q, in_q;
  logic [3:0] sig_n;
  logic [7:0] sc_n;
  logic [1:0] lv_n;
  logic [6:0] tl_n;
  logic       dead_n, end_n;
  logic       in_game, succ, lost, win, lose;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (start_btn),
    .press_pulse(press)
  );

  always_comb begin
    sig_n   = SIG_KEEP;
    sc_n    = score;
    lv_n    = lives;
    tl_n    = time_left;
    dead_n  = dead_q;
    end_n   = end_q;
    win     = 1'b0;
    lose    = 1'b0;
    in_game = state == ST_IN;
    succ    = hit_valid && hit_result == HIT_SUCC;
    lost    = hit_valid && hit_result == HIT_LOST;
    if (press && !in_game) begin
      sig_n  = SIG_START;
      sc_n   = '0;
      lv_n   = 2'(INIT_LIVES);
      tl_n   = 7'(TIME_LIMIT);
      dead_n = is_dead(mode);
      end_n  = 1'b0;
    end else if (in_game && !end_q) begin
      if (succ && score != 8'hFF)
        sc_n = score + 8'd1;
      if (dead_q && lost && lives != 2'd0)
        lv_n = lives - 2'd1;
      if (!dead_q && tick_1s && time_left != 7'd0)
        tl_n = time_left - 7'd1;
      win  = int'(sc_n) >= TARGET_SCORE;
      lose = dead_q ? (lv_n == 2'd0) : (tl_n == 7'd0);
      if (win) begin
        sig_n = SIG_WIN;
        end_n = 1'b1;
      end else if (lose) begin
        sig_n = SIG_LOST;
        end_n = 1'b1;
      end
    end else if (in_q && !in_game) begin
      // Game left inGame without a win/lose event.
      end_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gameSig   <= SIG_KEEP;
      score     <= '0;
      lives     <= 2'(INIT_LIVES);
      time_left <= 7'(TIME_LIMIT);
      dead_q    <= 1'b0;
      end_q     <= 1'b1;
      in_q      <= 1'b0;
    end else begin
      gameSig   <= sig_n;
      score     <= sc_n;
      lives     <= lv_n;
      time_left <= tl_n;
      dead_q    <= dead_n;
      end_q     <= end_n;
      in_q      <= in_game;
    end
  end

endmodule
